msft_dv_tb_clk_en_ctrl: RTL

Clock-enable sequencer for the DV testbench gated clock. It collects level clock requests from up to NUM_REQ bench agents plus a force-on override. It drives the clock generator's `en_i` with a wake settle period and an idle hold-off before gating. Each requester gets an acknowledge once the gated clock is stable, and gating events are counted for coverage.

---
 rtl/msft_dv_tb_clk_en_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/msft_dv_tb_clk_en_ctrl.sv
// Clock-enable sequencer for the DV gated clock: merges level requests and a
// force-on override, inserts a wake settle period and an idle hold-off before gating.
module msft_dv_tb_clk_en_ctrl #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               force_on_i,
    output logic               en_o,
    output logic [NUM_REQ-1:0] ack_o,
    output logic [1:0]         state_o,
    output logic [15:0]        gate_cnt_o
);

    localparam int unsigned GCNT_W = 16;
    localparam logic [CNT_W-1:0]  WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [GCNT_W-1:0] GCNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_e;

    state_e              state_q;
    logic                en_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [GCNT_W-1:0]   gate_cnt_q;
    logic [GCNT_W-1:0]   gate_cnt_d;
    logic                any_req;

    assign any_req = (|req_i) | force_on_i;

    // Saturating increment so coverage never wraps back to a small count.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        if (gate_cnt_q != GCNT_MAX) begin
            gate_cnt_d = gate_cnt_q + GCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= ST_OFF;
            en_q       <= 1'b0;
            cnt_q      <= '0;
            gate_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (any_req) begin
                        state_q <= ST_WAKE;
                        cnt_q   <= WAKE_LOAD;
                        en_q    <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    // Wake cannot be aborted; a dropped request exits via IDLE.
                    if (cnt_q == '0) begin
                        state_q <= ST_ON;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (!any_req) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= IDLE_LOAD;
                    end
                end
                ST_IDLE: begin
                    if (any_req) begin
                        state_q <= ST_ON;
                    end else if (cnt_q == '0) begin
                        state_q    <= ST_OFF;
                        en_q       <= 1'b0;
                        gate_cnt_q <= gate_cnt_d;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    // Grant follows the requester level only while the clock is settled on.
    assign ack_o      = (state_q == ST_ON) ? req_i : '0;
    assign en_o       = en_q;
    assign state_o    = state_q;
    assign gate_cnt_o = gate_cnt_q;

endmodule
